// File: rtl/serving_loader_pkg.sv
// Shared constants for the serving_loader boot-image loader: FSM state encoding,
// word lane count and sticky error bit positions.
package serving_loader_pkg;

  localparam int LANES   = 4;
  localparam int ERR_OVF = 0;
  localparam int ERR_VFY = 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FILL   = 3'd1,
    ST_WRITE  = 3'd2,
    ST_VERIFY = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  // Expands a byte-lane select into a 32-bit bit mask.
  function automatic logic [31:0] sel_mask(input logic [3:0] sel);
    logic [31:0] m;
    for (int i = 0; i < LANES; i++) m[i*8 +: 8] = {8{sel[i]}};
    return m;
  endfunction

endpackage

// File: rtl/serving_loader_pack.sv
// Byte-to-word packer: collects up to four bytes little-endian into one word and
// reports which lanes hold data. Unfilled lanes read as zero.
module serving_loader_pack
  import serving_loader_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_clr,
  input  logic        i_push,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_dat,
  output logic [3:0]  o_sel,
  output logic [1:0]  o_idx
);

  logic [2:0]  r_cnt;
  logic [31:0] r_dat;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= 3'd0;
      r_dat <= 32'd0;
    end else if (i_clr) begin
      r_cnt <= 3'd0;
      r_dat <= 32'd0;
    end else if (i_push) begin
      r_dat[{r_cnt[1:0], 3'b000} +: 8] <= i_byte;
      r_cnt                            <= r_cnt + 3'd1;
    end
  end

  always_comb begin
    o_sel = 4'd0;
    for (int i = 0; i < LANES; i++) o_sel[i] = (r_cnt > 3'(i));
  end

  assign o_dat = r_dat;
  assign o_idx = r_cnt[1:0];

endmodule

// File: rtl/serving_loader.sv
// Streams a byte image into a shared byte RAM over Wishbone while holding the CPU
// in reset. Optional readback check enabled by defining SERVING_LOADER_VERIFY_EN.
module serving_loader
  import serving_loader_pkg::*;
#(
  parameter int depth = 256,
  parameter int aw    = $clog2(depth)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_start,
  input  logic          i_byte_valid,
  input  logic [7:0]    i_byte,
  input  logic          i_byte_last,
  output logic          o_byte_ready,
  output logic [aw-1:2] o_wb_adr,
  output logic [31:0]   o_wb_dat,
  output logic [3:0]    o_wb_sel,
  output logic          o_wb_we,
  output logic          o_wb_stb,
  input  logic [31:0]   i_wb_rdt,
  input  logic          i_wb_ack,
  output logic          o_cpu_rst,
  output logic          o_done,
  output logic [1:0]    o_err,
  output logic [2:0]    o_dbg_state
);

  // Handshakes: a byte moves when i_byte_valid && o_byte_ready at a rising edge;
  // a bus cycle holds stb/adr/dat/sel/we steady until the edge that sees i_wb_ack,
  // and stb falls on the following cycle.
  state_t          r_state;
  logic [aw-3:0]   r_adr;
  logic            r_wrapped;
  logic            r_last;
  logic [1:0]      r_err;

  logic            w_start;
  logic            w_push;
  logic            w_clr;
  logic            w_word_done;
  logic            w_vfy_bad;
  logic [31:0]     w_dat;
  logic [3:0]      w_sel;
  logic [1:0]      w_idx;

  assign w_start = i_start && (r_state == ST_IDLE || r_state == ST_DONE);
  assign w_push  = (r_state == ST_FILL) && i_byte_valid && !r_wrapped;
  assign w_clr   = w_start || w_word_done;

`ifdef SERVING_LOADER_VERIFY_EN
  assign w_word_done = (r_state == ST_VERIFY) && i_wb_ack;
  assign w_vfy_bad   = |((i_wb_rdt ^ w_dat) & sel_mask(w_sel));
`else
  logic w_unused_rdt;
  assign w_word_done  = (r_state == ST_WRITE) && i_wb_ack;
  assign w_vfy_bad    = 1'b0;
  assign w_unused_rdt = ^i_wb_rdt;
`endif

  serving_loader_pack u_pack (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (w_clr),
    .i_push  (w_push),
    .i_byte  (i_byte),
    .o_dat   (w_dat),
    .o_sel   (w_sel),
    .o_idx   (w_idx)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_adr     <= '0;
      r_wrapped <= 1'b0;
      r_last    <= 1'b0;
      r_err     <= 2'b00;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (i_start) begin
            r_state   <= ST_FILL;
            r_adr     <= '0;
            r_wrapped <= 1'b0;
            r_last    <= 1'b0;
            r_err     <= 2'b00;
          end
        end
        ST_FILL: begin
          // Once the address has wrapped the RAM is full; further bytes are dropped.
          if (i_byte_valid) begin
            if (r_wrapped) begin
              r_err[ERR_OVF] <= 1'b1;
              r_state        <= ST_DONE;
            end else if (w_idx == 2'd3 || i_byte_last) begin
              r_last  <= i_byte_last;
              r_state <= ST_WRITE;
            end
          end
        end
`ifdef SERVING_LOADER_VERIFY_EN
        ST_WRITE: begin
          if (i_wb_ack) r_state <= ST_VERIFY;
        end
        ST_VERIFY: begin
          if (i_wb_ack && w_vfy_bad) r_err[ERR_VFY] <= 1'b1;
        end
`else
        ST_WRITE: ;
`endif
        default: r_state <= ST_IDLE;
      endcase

      if (w_word_done) begin
        r_adr   <= r_adr + 1'b1;
        r_state <= r_last ? ST_DONE : ST_FILL;
        if (&r_adr) r_wrapped <= 1'b1;
      end
    end
  end

  assign o_wb_adr     = r_adr;
  assign o_wb_dat     = w_dat;
  assign o_wb_sel     = (r_state == ST_VERIFY) ? 4'hf : w_sel;
  assign o_wb_we      = (r_state == ST_WRITE);
  assign o_wb_stb     = (r_state == ST_WRITE) || (r_state == ST_VERIFY);
  assign o_byte_ready = (r_state == ST_FILL);
  assign o_cpu_rst    = (r_state == ST_FILL) || (r_state == ST_WRITE) || (r_state == ST_VERIFY);
  assign o_done       = (r_state == ST_DONE);
  assign o_err        = r_err;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_serving_loader.sv
// Directed bench for serving_loader (depth=16): table of byte images plus
// sequences for ack latency, start/valid masking, overflow, reset and readback.
module tb_serving_loader;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int W     = (AW - 2) + 32 + 4;

  logic          i_clk = 1'b0;
  logic          i_rst_n;
  logic          i_start;
  logic          i_byte_valid;
  logic [7:0]    i_byte;
  logic          i_byte_last;
  logic          o_byte_ready;
  logic [AW-1:2] o_wb_adr;
  logic [31:0]   o_wb_dat;
  logic [3:0]    o_wb_sel;
  logic          o_wb_we;
  logic          o_wb_stb;
  logic [31:0]   i_wb_rdt;
  logic          i_wb_ack;
  logic          o_cpu_rst;
  logic          o_done;
  logic [1:0]    o_err;
  logic [2:0]    o_dbg_state;

  serving_loader #(.depth(DEPTH), .aw(AW)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_start      (i_start),
    .i_byte_valid (i_byte_valid),
    .i_byte       (i_byte),
    .i_byte_last  (i_byte_last),
    .o_byte_ready (o_byte_ready),
    .o_wb_adr     (o_wb_adr),
    .o_wb_dat     (o_wb_dat),
    .o_wb_sel     (o_wb_sel),
    .o_wb_we      (o_wb_we),
    .o_wb_stb     (o_wb_stb),
    .i_wb_rdt     (i_wb_rdt),
    .i_wb_ack     (i_wb_ack),
    .o_cpu_rst    (o_cpu_rst),
    .o_done       (o_done),
    .o_err        (o_err),
    .o_dbg_state  (o_dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 i_clk = ~i_clk;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic exp_push(input logic [1:0] a, input logic [31:0] d, input logic [3:0] s);
    exp_q.push_back({a, d, s});
  endtask

  // ---------------- Wishbone responder / scoreboard ----------------
  int          ack_lat = 5;
  int          ack_cnt;
  int          n_stb = 0;
  logic        prev_stb = 1'b0;
  logic [31:0] mem [4];
  logic [31:0] corrupt = 32'd0;

  initial for (int i = 0; i < 4; i++) mem[i] = 32'd0;

  assign i_wb_rdt = mem[o_wb_adr] ^ corrupt;

  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      i_wb_ack <= 1'b0;
      ack_cnt  <= 0;
    end else if (i_wb_ack) begin
      i_wb_ack <= 1'b0;
      ack_cnt  <= 0;
    end else if (o_wb_stb) begin
      if (ack_cnt >= ack_lat - 1) i_wb_ack <= 1'b1;
      else ack_cnt <= ack_cnt + 1;
    end
  end

  always @(negedge i_clk) begin
    if (o_wb_stb && !prev_stb) n_stb++;
    prev_stb = o_wb_stb;
    if (i_rst_n && i_wb_ack && o_wb_stb && o_wb_we) begin
      for (int i = 0; i < 4; i++) if (o_wb_sel[i]) mem[o_wb_adr][i*8 +: 8] = o_wb_dat[i*8 +: 8];
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write got=%0h exp=none", {o_wb_adr, o_wb_dat, o_wb_sel});
      end else begin
        chk("wb_write", {o_wb_adr, o_wb_dat, o_wb_sel}, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_load();
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    chk("start_cpu_rst", o_cpu_rst, 1);
    chk("start_ready", o_byte_ready, 1);
    chk("start_done", o_done, 0);
    chk("start_err", o_err, 0);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    int t = 0;
    i_byte_valid = 1'b1;
    i_byte       = b;
    i_byte_last  = last;
    while (!o_byte_ready && t < 200) begin
      @(negedge i_clk);
      t++;
    end
    if (!o_byte_ready) chk("byte_accept_timeout", o_byte_ready, 1);
    @(negedge i_clk);
    i_byte_valid = 1'b0;
    i_byte_last  = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    while (!o_done && t < 400) begin
      @(negedge i_clk);
      t++;
    end
    chk("done_wait", o_done, 1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int          n;
    logic [63:0] bytes;
    int          lat;
    int          nw;
    logic [31:0] d0;
    logic [3:0]  s0;
    logic [31:0] d1;
    logic [3:0]  s1;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int stb0;
    int waitc;

    vecs[0] = '{4, 64'h0000_0000_4433_2211, 5, 1, 32'h44332211, 4'hf, 32'h0, 4'h0};
    vecs[1] = '{5, 64'h0000_00EE_DDCC_BBAA, 5, 2, 32'hDDCCBBAA, 4'hf, 32'h000000EE, 4'h1};
    vecs[2] = '{1, 64'h0000_0000_0000_005A, 1, 1, 32'h0000005A, 4'h1, 32'h0, 4'h0};
    vecs[3] = '{3, 64'h0000_0000_0003_0201, 2, 1, 32'h00030201, 4'h7, 32'h0, 4'h0};
    vecs[4] = '{6, 64'h0000_1514_1312_1110, 3, 2, 32'h13121110, 4'hf, 32'h00001514, 4'h3};
    vecs[5] = '{8, 64'h0807_0605_0403_0201, 1, 2, 32'h04030201, 4'hf, 32'h08070605, 4'hf};

    i_rst_n      = 1'b0;
    i_start      = 1'b0;
    i_byte_valid = 1'b0;
    i_byte       = 8'd0;
    i_byte_last  = 1'b0;
    repeat (3) @(negedge i_clk);

    chk("rst_stb", o_wb_stb, 0);
    chk("rst_we", o_wb_we, 0);
    chk("rst_sel", o_wb_sel, 0);
    chk("rst_adr", o_wb_adr, 0);
    chk("rst_dat", o_wb_dat, 0);
    chk("rst_ready", o_byte_ready, 0);
    chk("rst_cpu_rst", o_cpu_rst, 0);
    chk("rst_done", o_done, 0);
    chk("rst_err", o_err, 0);
    chk("rst_state", o_dbg_state, serving_loader_pkg::ST_IDLE);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    chk("idle_ready", o_byte_ready, 0);

    // Table-driven images
    for (int v = 0; v < 6; v++) begin
      ack_lat = vecs[v].lat;
      stb0    = n_stb;
      start_load();
      exp_push(2'd0, vecs[v].d0, vecs[v].s0);
      if (vecs[v].nw > 1) exp_push(2'd1, vecs[v].d1, vecs[v].s1);
      for (int i = 0; i < vecs[v].n; i++)
        send_byte(vecs[v].bytes[8*i +: 8], (i == vecs[v].n - 1));
      wait_done();
      chk("vec_cpu_rst", o_cpu_rst, 0);
      chk("vec_ready", o_byte_ready, 0);
      chk("vec_err", o_err, 0);
      chk("vec_pending", exp_q.size(), 0);
      chk("vec_nstb", n_stb - stb0, vecs[v].nw);
    end

    // Slow responder: bus signals hold until ack, stb drops right after
    ack_lat = 7;
    start_load();
    exp_push(2'd0, 32'h44332211, 4'hf);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    send_byte(8'h44, 1'b1);
    waitc = 0;
    while (!i_wb_ack && waitc < 50) begin
      chk("slow_stb", o_wb_stb, 1);
      chk("slow_ready", o_byte_ready, 0);
      chk("slow_adr", o_wb_adr, 0);
      chk("slow_dat", o_wb_dat, 32'h44332211);
      waitc++;
      @(negedge i_clk);
    end
    chk("slow_latency", waitc, 7);
    chk("slow_stb_at_ack", o_wb_stb, 1);
    @(negedge i_clk);
`ifdef SERVING_LOADER_VERIFY_EN
    chk("slow_we_after_ack", o_wb_we, 0);
`else
    chk("slow_stb_after_ack", o_wb_stb, 0);
`endif
    wait_done();

    // i_start ignored in FILL; i_byte_valid ignored in DONE
    ack_lat = 5;
    stb0    = n_stb;
    start_load();
    exp_push(2'd0, 32'hDDCCBBAA, 4'hf);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    send_byte(8'hCC, 1'b0);
    send_byte(8'hDD, 1'b1);
    wait_done();
    i_byte_valid = 1'b1;
    i_byte       = 8'h77;
    i_byte_last  = 1'b1;
    repeat (5) @(negedge i_clk);
    chk("done_ready", o_byte_ready, 0);
    chk("done_hold", o_done, 1);
    i_byte_valid = 1'b0;
    i_byte_last  = 1'b0;
    chk("mask_nstb", n_stb - stb0, 1);
    chk("mask_pending", exp_q.size(), 0);

    // Overflow: 17 bytes into a 16-byte RAM
    stb0 = n_stb;
    start_load();
    exp_push(2'd0, 32'h03020100, 4'hf);
    exp_push(2'd1, 32'h07060504, 4'hf);
    exp_push(2'd2, 32'h0B0A0908, 4'hf);
    exp_push(2'd3, 32'h0F0E0D0C, 4'hf);
    for (int i = 0; i < 17; i++) send_byte(8'(i), (i == 16));
    wait_done();
    repeat (10) @(negedge i_clk);
    chk("ovf_err", o_err, 2'b01);
    chk("ovf_nstb", n_stb - stb0, 4);
    chk("ovf_pending", exp_q.size(), 0);
    chk("ovf_stb", o_wb_stb, 0);

    // Reset asserted mid write cycle
    ack_lat = 7;
    start_load();
    exp_push(2'd0, 32'h04030201, 4'hf);
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h03, 1'b0);
    send_byte(8'h04, 1'b1);
    @(negedge i_clk);
    chk("pre_rst_stb", o_wb_stb, 1);
    i_rst_n = 1'b0;
    #1;
    chk("mid_rst_stb", o_wb_stb, 0);
    chk("mid_rst_we", o_wb_we, 0);
    chk("mid_rst_sel", o_wb_sel, 0);
    chk("mid_rst_adr", o_wb_adr, 0);
    chk("mid_rst_dat", o_wb_dat, 0);
    chk("mid_rst_cpu_rst", o_cpu_rst, 0);
    chk("mid_rst_done", o_done, 0);
    chk("mid_rst_err", o_err, 0);
    exp_q.delete();
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    ack_lat = 5;
    start_load();
    exp_push(2'd0, 32'hD4C3B2A1, 4'hf);
    send_byte(8'hA1, 1'b0);
    send_byte(8'hB2, 1'b0);
    send_byte(8'hC3, 1'b0);
    send_byte(8'hD4, 1'b1);
    wait_done();
    chk("reload_pending", exp_q.size(), 0);
    chk("reload_err", o_err, 0);

`ifdef SERVING_LOADER_VERIFY_EN
    // Readback corruption on a selected lane vs an unselected lane
    corrupt = 32'h0000FF00;
    start_load();
    exp_push(2'd0, 32'h44332211, 4'hf);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    send_byte(8'h44, 1'b1);
    wait_done();
    chk("vfy_bad_err", o_err, 2'b10);
    corrupt = 32'hFF000000;
    start_load();
    exp_push(2'd0, 32'h00002211, 4'h3);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b1);
    wait_done();
    chk("vfy_masked_err", o_err, 2'b00);
    corrupt = 32'd0;
`endif

    repeat (3) @(negedge i_clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    bad++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serving_loader.md
SERVING_LOADER -- requirements
Module: serving_loader

Interface
REQ-001 Parameters SHALL be: depth, default 256, RAM size in bytes; aw, default $clog2(depth), byte address width.
REQ-002 i_clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-003 i_rst_n  in  1  reset; asynchronous assert, active-low.
REQ-004 i_start  in  1  single-cycle pulse that begins a load at word address 0.
REQ-005 i_byte_valid, i_byte[7:0], i_byte_last  in  1/8/1  byte stream; last marks the final byte of an image.
REQ-006 o_byte_ready  out  1  byte accepted on a cycle where valid and ready are both high.
REQ-007 o_wb_adr[aw-1:2], o_wb_dat[31:0], o_wb_sel[3:0], o_wb_we, o_wb_stb  out  Wishbone initiator to the shared byte RAM.
REQ-008 i_wb_rdt[31:0], i_wb_ack  in  Wishbone responder data and ack.
REQ-009 o_cpu_rst  out  1  holds the CPU in reset while loading; o_done  out  1  image loaded; o_err[1:0]  out  sticky: bit0 overflow, bit1 verify mismatch.

Function
REQ-010 States SHALL be IDLE, FILL, WRITE, VERIFY (macro only), DONE.
REQ-011 IDLE: o_byte_ready=0, o_cpu_rst=0; i_start -> FILL with address=0, byte index=0, o_err=0, o_done=0, o_cpu_rst=1.
REQ-012 FILL: o_byte_ready=1; each accepted byte SHALL go to lane index (little-endian: first byte in [7:0]), index +1.
REQ-013 FILL -> WRITE on acceptance of the 4th byte or of any byte with i_byte_last=1.
REQ-014 o_wb_sel SHALL have one bit set per filled lane (e.g. 2 bytes then last -> 4'b0011); unfilled lanes drive 0.
REQ-015 WRITE: o_wb_stb=1, o_wb_we=1, o_byte_ready=0; adr/dat/sel SHALL remain stable until the cycle i_wb_ack=1.
REQ-016 On ack, o_wb_stb SHALL deassert the next cycle, index clears, address +1; next state FILL, or DONE if the word held the last byte.
REQ-017 Initiator SHALL tolerate any ack latency (minimum 1 cycle, responder typically 5) and SHALL never hold stb after ack.
REQ-018 Overflow: a byte accepted in FILL when address has wrapped past depth/4-1 SHALL set o_err[0], be dropped, and force DONE.
REQ-019 DONE: o_done=1, o_cpu_rst=0, o_byte_ready=0; i_start restarts as in REQ-011.
REQ-020 i_start in FILL/WRITE/VERIFY SHALL be ignored; i_byte_valid in IDLE/DONE SHALL be ignored.

Reset
REQ-021 While i_rst_n=0: state IDLE, o_wb_stb=0, o_wb_we=0, o_wb_sel=0, o_wb_adr=0, o_wb_dat=0, o_byte_ready=0, o_cpu_rst=0, o_done=0, o_err=0.
REQ-022 Reset mid-transaction SHALL drop stb immediately (asynchronously); the partial image is discarded.

Configuration
REQ-023 Macro SERVING_LOADER_VERIFY_EN defined: after each write ack, enter VERIFY, issue read (we=0, same adr, sel=4'hf) until ack, compare i_wb_rdt against written data on selected lanes only; mismatch sets o_err[1]; then proceed per REQ-016.
REQ-024 Macro undefined: no VERIFY state, o_err[1] tied 0, WRITE ack transitions directly per REQ-016.

Structure
REQ-025 Package serving_loader_pkg SHALL hold the state enum, lane-count constant (4) and error-bit indices.
REQ-026 One sub-module, serving_loader_pack: byte-to-word packer (lane register, index, sel generation); FSM and Wishbone stay in serving_loader.

Verification
REQ-027 Bytes 11,22,33,44 (last on 44) -> one write adr 0, dat 0x44332211, sel 4'hf; o_done=1, o_cpu_rst=0.
REQ-028 Bytes AA,BB,CC,DD,EE(last) -> writes adr0 0xDDCCBBAA sel 4'hf, adr1 dat[7:0]=0xEE sel 4'b0001.
REQ-029 Responder acks after 7 cycles -> stb/adr/dat stable 7 cycles, stb low the cycle after ack, o_byte_ready=0 throughout.
REQ-030 depth=16, 17 bytes -> 4 writes, 17th byte sets o_err[0], DONE, no 5th stb.
REQ-031 i_rst_n low during WRITE stb -> stb low same cycle, all outputs at reset values; new i_start reloads from adr 0.
REQ-032 With SERVING_LOADER_VERIFY_EN, responder corrupts readback byte 1 -> o_err[1]=1; corrupting an unselected lane -> o_err[1]=0.
